// File: rtl/login_pkg.sv
// Shared definitions for the login session sequencer: state encoding,
// logout retry interval and tick counter width.
package login_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOCKED  = 2'd1,
        S_SESSION = 2'd2,
        S_LOGOUT  = 2'd3
    } state_t;

    // Cycles spent in LOGOUT with LoggedIn still high before force_logout re-pulses
    localparam int unsigned LOGOUT_RETRY = 8;
    localparam int unsigned RETRY_W      = $clog2(LOGOUT_RETRY);

    // Width of the lockout / idle tick counter
    localparam int unsigned TCNT_W = 16;

endpackage

// File: rtl/login_session_ctrl_tick_gen.sv
// Timing-tick prescaler: counts 0..TICK_DIV-1 and flags the terminal count.
// 'clear' restarts the count so a fresh interval starts on the next cycle.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;

    // Free-running modulo-TICK_DIV counter with synchronous restart
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/login_session_ctrl.sv
// Login session sequencer: gates user digit loads, counts failed password
// attempts with a timed lockout, tracks the session idle timeout and drives
// the logout handshake back into authentication.
module login_session_ctrl
    import login_pkg::*;
#(
    parameter int unsigned MAX_ATTEMPTS     = 3,
    parameter int unsigned TICK_DIV         = 50000000,
    parameter int unsigned LOCK_TICKS       = 30,
    parameter int unsigned IDLE_TICKS       = 120,
    parameter int unsigned GUEST_IDLE_TICKS = 30,
    parameter int unsigned WARN_TICKS       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UserLoad,
    input  logic       LoggedIn,
    input  logic       PswdFail,
    input  logic       isGuest,
    input  logic       logout_req,
    output logic       UserLoad_gated,
    output logic       force_logout,
    output logic       lockout,
    output logic       session_active,
    output logic       timeout_warn,
    output logic [2:0] attempts_left
);

    localparam logic [2:0]        MAX_ATT = 3'(MAX_ATTEMPTS);
    localparam logic [TCNT_W-1:0] LOCK_T  = TCNT_W'(LOCK_TICKS);
    localparam logic [TCNT_W-1:0] WARN_T  = TCNT_W'(WARN_TICKS);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(LOGOUT_RETRY - 1);

    state_t              state_q, state_d;
    logic [TCNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]          att_q, att_d;
    logic                guest_q, guest_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                force_d;
    logic                restart;
    logic                clear;
    logic                tick;
    logic                lockout_q, session_q, warn_q, force_q;

    // Idle timeout reload value for the session type
    function automatic logic [TCNT_W-1:0] idle_load(input logic guest);
        return guest ? TCNT_W'(GUEST_IDLE_TICKS) : TCNT_W'(IDLE_TICKS);
    endfunction

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    // Next-state, counter and attempt bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        att_d   = att_q;
        guest_d = guest_q;
        retry_d = retry_q;
        force_d = 1'b0;
        restart = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A valid login takes priority over a simultaneous failure
                if (LoggedIn) begin
                    state_d = S_SESSION;
                    guest_d = isGuest;
                    cnt_d   = idle_load(isGuest);
                    att_d   = MAX_ATT;
                end else if (PswdFail) begin
                    if (att_q <= 3'd1) begin
                        state_d = S_LOCKED;
                        cnt_d   = LOCK_T;
                        att_d   = 3'd0;
                    end else begin
                        att_d = att_q - 3'd1;
                    end
                end
            end
            S_LOCKED: begin
                if (tick) begin
                    if (cnt_q <= TCNT_W'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        att_d   = MAX_ATT;
                    end else begin
                        cnt_d = cnt_q - TCNT_W'(1);
                    end
                end
            end
            S_SESSION: begin
                if (logout_req) begin
                    state_d = S_LOGOUT;
                    retry_d = '0;
                    force_d = 1'b1;
                end else if (!LoggedIn) begin
                    state_d = S_IDLE;
                end else if (UserLoad) begin
                    // User activity restarts the full idle interval
                    cnt_d   = idle_load(guest_q);
                    restart = 1'b1;
                end else if (tick) begin
                    if (cnt_q <= TCNT_W'(1)) begin
                        state_d = S_LOGOUT;
                        cnt_d   = '0;
                        retry_d = '0;
                        force_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - TCNT_W'(1);
                    end
                end
            end
            S_LOGOUT: begin
                if (!LoggedIn) begin
                    state_d = S_IDLE;
                    att_d   = MAX_ATT;
                end else if (retry_q == RETRY_LAST) begin
                    // Authentication has not dropped the login yet: ask again
                    retry_d = '0;
                    force_d = 1'b1;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign clear = restart || (state_d != state_q);

    // State, counters and Moore outputs registered together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            att_q     <= MAX_ATT;
            guest_q   <= 1'b0;
            retry_q   <= '0;
            lockout_q <= 1'b0;
            session_q <= 1'b0;
            warn_q    <= 1'b0;
            force_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            att_q     <= att_d;
            guest_q   <= guest_d;
            retry_q   <= retry_d;
            lockout_q <= (state_d == S_LOCKED);
            session_q <= (state_d == S_SESSION);
            warn_q    <= (state_d == S_SESSION) && (cnt_d <= WARN_T);
            force_q   <= force_d;
        end
    end

    assign UserLoad_gated = UserLoad && ((state_q == S_IDLE) || (state_q == S_SESSION));
    assign force_logout   = force_q;
    assign lockout        = lockout_q;
    assign session_active = session_q;
    assign timeout_warn   = warn_q;
    assign attempts_left  = att_q;

endmodule

// File: tb/tb_login_session_ctrl.sv
// Self-checking bench for login_session_ctrl: directed scenarios followed by
// randomized traffic, compared each cycle against a deadline-based model.
module tb_login_session_ctrl;

    localparam int MAXA = 3;
    localparam int TD   = 4;
    localparam int LT   = 3;
    localparam int IT   = 5;
    localparam int GT   = 4;
    localparam int WT   = 2;

    localparam int MI = 0;  // idle
    localparam int ML = 1;  // locked
    localparam int MS = 2;  // session
    localparam int MO = 3;  // logging out

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       UserLoad = 1'b0;
    logic       LoggedIn = 1'b0;
    logic       PswdFail = 1'b0;
    logic       isGuest = 1'b0;
    logic       logout_req = 1'b0;
    logic       UserLoad_gated;
    logic       force_logout;
    logic       lockout;
    logic       session_active;
    logic       timeout_warn;
    logic [2:0] attempts_left;

    int tests = 0;
    int fails = 0;

    // Model: mode, attempts, cycles elapsed since last interval start,
    // interval length in ticks, cycles since entering logout, latched guest flag
    int m_mode, m_att, m_el, m_load, m_age;
    bit m_guest;

    login_session_ctrl #(
        .MAX_ATTEMPTS     (MAXA),
        .TICK_DIV         (TD),
        .LOCK_TICKS       (LT),
        .IDLE_TICKS       (IT),
        .GUEST_IDLE_TICKS (GT),
        .WARN_TICKS       (WT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .UserLoad       (UserLoad),
        .LoggedIn       (LoggedIn),
        .PswdFail       (PswdFail),
        .isGuest        (isGuest),
        .logout_req     (logout_req),
        .UserLoad_gated (UserLoad_gated),
        .force_logout   (force_logout),
        .lockout        (lockout),
        .session_active (session_active),
        .timeout_warn   (timeout_warn),
        .attempts_left  (attempts_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = MI;
        m_att   = MAXA;
        m_el    = 0;
        m_load  = 0;
        m_age   = 0;
        m_guest = 1'b0;
    endtask

    // One clock edge of the reference behaviour using the current inputs
    task automatic model_step();
        case (m_mode)
            MI: begin
                if (LoggedIn) begin
                    m_mode  = MS;
                    m_guest = isGuest;
                    m_load  = isGuest ? GT : IT;
                    m_el    = 0;
                    m_att   = MAXA;
                end else if (PswdFail) begin
                    if (m_att == 1) begin
                        m_mode = ML;
                        m_load = LT;
                        m_el   = 0;
                        m_att  = 0;
                    end else begin
                        m_att = m_att - 1;
                    end
                end
            end
            ML: begin
                m_el++;
                if (m_el == m_load * TD) begin
                    m_mode = MI;
                    m_att  = MAXA;
                end
            end
            MS: begin
                if (logout_req) begin
                    m_mode = MO;
                    m_age  = 0;
                end else if (!LoggedIn) begin
                    m_mode = MI;
                end else if (UserLoad) begin
                    m_el   = 0;
                    m_load = m_guest ? GT : IT;
                end else begin
                    m_el++;
                    if (m_el == m_load * TD) begin
                        m_mode = MO;
                        m_age  = 0;
                    end
                end
            end
            default: begin
                if (!LoggedIn) begin
                    m_mode = MI;
                    m_att  = MAXA;
                end else begin
                    m_age++;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("lockout", lockout, 16'(m_mode == ML));
        chk("session_active", session_active, 16'(m_mode == MS));
        chk("timeout_warn", timeout_warn, 16'((m_mode == MS) && ((m_load - m_el / TD) <= WT)));
        chk("force_logout", force_logout, 16'((m_mode == MO) && (m_age % 8 == 0)));
        chk("attempts_left", attempts_left, 16'(m_att));
    endtask

    // Check the combinational gate, clock once, advance the model, check outputs
    task automatic step();
        #1;
        chk("UserLoad_gated", UserLoad_gated, 16'(UserLoad && (m_mode == MI || m_mode == MS)));
        @(posedge clk);
        if (rst) model_step();
        #1;
        check_outputs();
    endtask

    task automatic fail_pulse();
        PswdFail = 1'b1;
        step();
        PswdFail = 1'b0;
    endtask

    initial begin
        int lk, n, wn, fo, pulses, k;
        bit found;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_attempts", attempts_left, 16'd3);
        chk("rst_lockout", lockout, 16'd0);
        chk("rst_session", session_active, 16'd0);
        chk("rst_force", force_logout, 16'd0);
        chk("rst_warn", timeout_warn, 16'd0);
        rst = 1'b1;
        step();
        step();

        // Three failures lock the user out for LOCK_TICKS*TICK_DIV cycles
        fail_pulse();
        chk("att_after_1", attempts_left, 16'd2);
        step();
        fail_pulse();
        chk("att_after_2", attempts_left, 16'd1);
        step();
        fail_pulse();
        chk("att_locked", attempts_left, 16'd0);
        lk = int'(lockout);
        for (int i = 0; i < 16; i++) begin
            UserLoad = 1'($urandom % 2);
            step();
            lk += int'(lockout);
        end
        UserLoad = 1'b0;
        chk("lock_len", 16'(lk), 16'd12);
        chk("att_restored", attempts_left, 16'd3);

        // Registered session times out after IDLE_TICKS ticks
        isGuest  = 1'b0;
        LoggedIn = 1'b1;
        step();
        chk("sess_enter", session_active, 16'd1);
        n = 0; wn = 0; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            n++;
            if (timeout_warn && wn == 0) wn = n;
            if (force_logout) found = 1'b1;
        end
        chk("warn_cycles", 16'(wn), 16'd12);
        chk("timeout_cycles", 16'(n), 16'd20);
        LoggedIn = 1'b0;
        step();
        chk("timeout_idle", session_active, 16'd0);

        // Periodic activity keeps the session alive
        LoggedIn = 1'b1;
        step();
        fo = 0;
        for (int i = 0; i < 75; i++) begin
            UserLoad = (i % 15 == 14);
            step();
            fo += int'(force_logout);
        end
        UserLoad = 1'b0;
        chk("keepalive_no_logout", 16'(fo), 16'd0);
        chk("keepalive_active", session_active, 16'd1);

        // Logout request beats a simultaneous UserLoad; re-pulse after 8 cycles
        logout_req = 1'b1;
        UserLoad   = 1'b1;
        step();
        logout_req = 1'b0;
        UserLoad   = 1'b0;
        chk("lr_force", force_logout, 16'd1);
        chk("lr_session", session_active, 16'd0);
        pulses = 0; k = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (force_logout) begin
                pulses++;
                k = i;
            end
        end
        chk("repulse_count", 16'(pulses), 16'd1);
        chk("repulse_gap", 16'(k), 16'd8);
        LoggedIn = 1'b0;
        step();
        step();
        chk("logout_att", attempts_left, 16'd3);

        // Login wins over a simultaneous final failure
        fail_pulse();
        fail_pulse();
        chk("att_one", attempts_left, 16'd1);
        PswdFail = 1'b1;
        LoggedIn = 1'b1;
        isGuest  = 1'b1;
        step();
        PswdFail = 1'b0;
        chk("race_session", session_active, 16'd1);
        chk("race_lockout", lockout, 16'd0);
        chk("race_att", attempts_left, 16'd3);
        LoggedIn = 1'b0;
        step();
        chk("drop_no_force", force_logout, 16'd0);

        // Asynchronous reset in the middle of a lockout
        fail_pulse();
        fail_pulse();
        fail_pulse();
        repeat (5) step();
        chk("pre_rst_lock", lockout, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("midlock_rst_lockout", lockout, 16'd0);
        chk("midlock_rst_att", attempts_left, 16'd3);
        chk("midlock_rst_session", session_active, 16'd0);
        step();
        rst = 1'b1;
        repeat (16) step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 60 == 0) LoggedIn = ~LoggedIn;
            isGuest    = 1'($urandom % 2);
            PswdFail   = ($urandom % 6 == 0);
            UserLoad   = ($urandom % 12 == 0);
            logout_req = ($urandom % 40 == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
